// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the instruction phase sequencer and its controller.
package phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

  // Phase in which the controller decodes a halt instruction.
  localparam logic [2:0] PH_HALT_CHK = 3'd4;
  // Final phase of an instruction; leaving it retires the instruction.
  localparam logic [2:0] PH_LAST     = 3'd7;

  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    return ph + 3'd1;
  endfunction

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// Memory wait-state counter: counts consecutive stalled cycles and flags the
// cycle in which the count would reach MAX_WAIT.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall,
  output logic o_expire
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  // The current stalled cycle is the MAX_WAIT-th consecutive one.
  assign w_at_limit = (r_count == CW'(MAX_WAIT - 1));
  assign o_expire   = i_stall && w_at_limit;

  // Count stalled cycles; any advancing or idle cycle, and the expiry itself, clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_stall || w_at_limit) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: steps a controller through phases 0..7, holds
// the phase during memory wait states, and handles run/step/halt control.
//
// state     | meaning
// ST_IDLE   | no instruction in flight, phase held at 0
// ST_RUN    | continuous execution
// ST_STEP   | executing one instruction, returns to IDLE after phase 7
// ST_HALTED | stopped by halt decode or memory timeout, phase held at 0
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt,
  input  logic             rd,
  input  logic             wr,
  input  logic             mem_ready,
  output logic [2:0]       phase,
  output logic             running,
  output logic             halted,
  output logic             stall,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_t       r_state, w_nxt_state;
  logic [2:0]       r_phase, w_nxt_phase;
  logic [CNT_W-1:0] r_instr_cnt, w_nxt_instr_cnt;
  logic             r_timeout, w_nxt_timeout;
  logic             r_stall, w_nxt_stall;
  logic             w_active;
  logic             w_stall;
  logic             w_expire;
  logic             w_retire;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_stall  = w_active && (rd || wr) && !mem_ready;
  assign w_retire = w_active && !w_stall && (r_phase == PH_LAST);

  wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .i_stall (w_stall),
    .o_expire(w_expire)
  );

  // State, phase, counters and flags; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= 3'd0;
      r_instr_cnt <= '0;
      r_timeout   <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_phase     <= w_nxt_phase;
      r_instr_cnt <= w_nxt_instr_cnt;
      r_timeout   <= w_nxt_timeout;
      r_stall     <= w_nxt_stall;
    end
  end

  // Next-state decode; priority is timeout, halt, retirement, then requests.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_phase     = r_phase;
    w_nxt_instr_cnt = r_instr_cnt;
    w_nxt_timeout   = r_timeout;
    w_nxt_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nxt_phase = 3'd0;
        if (run_req) begin
          w_nxt_state = ST_RUN;
        end else if (step_req) begin
          w_nxt_state = ST_STEP;
        end
      end
      ST_RUN, ST_STEP: begin
        if (w_expire) begin
          w_nxt_state   = ST_HALTED;
          w_nxt_phase   = 3'd0;
          w_nxt_timeout = 1'b1;
        end else if (!w_stall && (r_phase == PH_HALT_CHK) && halt) begin
          w_nxt_state = ST_HALTED;
          w_nxt_phase = 3'd0;
        end else begin
          if (w_stall) begin
            w_nxt_stall = 1'b1;
          end else begin
            w_nxt_phase = next_phase(r_phase);
          end
          if (w_retire) begin
            w_nxt_instr_cnt = r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_state == ST_STEP) begin
              w_nxt_state = ST_IDLE;
            end
          end else if ((r_state == ST_STEP) && run_req) begin
            w_nxt_state = ST_RUN;
          end
        end
      end
      ST_HALTED: begin
        w_nxt_phase = 3'd0;
        if (run_req) begin
          w_nxt_state   = ST_RUN;
          w_nxt_timeout = 1'b0;
        end else if (step_req) begin
          w_nxt_state = ST_STEP;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_phase = 3'd0;
      end
    endcase
  end

  assign phase       = r_phase;
  assign running     = w_active;
  assign halted      = (r_state == ST_HALTED);
  assign stall       = r_stall;
  assign mem_timeout = r_timeout;
  assign instr_count = r_instr_cnt;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer. The retired-instruction counter is
// narrowed to 8 bits so the wrap can be reached in a short run.
module tb_phase_sequencer;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             run_req;
  logic             step_req;
  logic             halt;
  logic             rd;
  logic             wr;
  logic             mem_ready;
  logic [2:0]       phase;
  logic             running;
  logic             halted;
  logic             stall;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_count;

  int errors;
  int checks;

  phase_sequencer #(
    .MAX_WAIT(15),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run_req    (run_req),
    .step_req   (step_req),
    .halt       (halt),
    .rd         (rd),
    .wr         (wr),
    .mem_ready  (mem_ready),
    .phase      (phase),
    .running    (running),
    .halted     (halted),
    .stall      (stall),
    .mem_timeout(mem_timeout),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ph, input logic run,
                         input logic hlt, input logic stl, input logic to,
                         input logic [CNT_W-1:0] cnt);
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".running"}, 32'(running), 32'(run));
    chk({tag, ".halted"}, 32'(halted), 32'(hlt));
    chk({tag, ".stall"}, 32'(stall), 32'(stl));
    chk({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(to));
    chk({tag, ".instr_count"}, 32'(instr_count), 32'(cnt));
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    run_req   = 1'b0;
    step_req  = 1'b0;
    halt      = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    tick();
    chk_all("idle_after_release", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Continuous run: two full instructions.
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("run_entry.running", 32'(running), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("run_seq.phase", 32'(phase), 32'(i % 8));
      tick();
    end
    chk_all("run_two_instr", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

    // Three wait states at phase 1.
    tick();
    chk("pre_stall.phase", 32'(phase), 32'd1);
    rd        = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold.phase", 32'(phase), 32'd1);
      chk("stall_hold.stall", 32'(stall), 32'd1);
    end
    rd        = 1'b0;
    mem_ready = 1'b1;
    tick();
    chk_all("stall_release", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

    // Halt decode at phase 4.
    tick();
    tick();
    chk("halt_pre.phase", 32'(phase), 32'd4);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk_all("halt", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    step_req = 1'b0;
    tick();
    chk_all("halt_hold", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);

    // Resume, then memory timeout after 15 waits at phase 0.
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk_all("resume", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    rd        = 1'b1;
    mem_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) begin
        chk_all("wait14", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
      end else if (k == 15) begin
        chk_all("timeout", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
      end else if (k == 20) begin
        chk_all("timeout_sticky", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
      end
    end
    rd        = 1'b0;
    mem_ready = 1'b1;
    run_req   = 1'b1;
    tick();
    run_req = 1'b0;
    chk_all("timeout_clear", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

    // step_req ignored in RUN; finish instruction and halt at phase 4.
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("run_ignores_step.phase", 32'(phase), 32'd1);
    for (int i = 0; i < 7; i++) tick();
    chk_all("run_retire3", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    for (int i = 0; i < 4; i++) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk_all("halt2", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);

    // Single step from HALTED.
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("step_entry.running", 32'(running), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("step_seq.phase", 32'(phase), 32'(i));
      tick();
    end
    chk_all("step_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
    tick();
    chk_all("step_idle_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);

    // Held step_req restarts a step right after completion.
    step_req = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk_all("step_level_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
    tick();
    step_req = 1'b0;
    chk_all("step_level_restart", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);

    // run_req promotes STEP to RUN mid-instruction.
    tick();
    tick();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("promote.phase", 32'(phase), 32'd3);
    for (int i = 0; i < 6; i++) tick();
    chk_all("promote_continues", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd6);

    // Counter wrap: 6 -> 255 -> 0.
    for (int i = 0; i < 7 + 248 * 8; i++) tick();
    chk("wrap_pre.instr_count", 32'(instr_count), 32'd255);
    chk("wrap_pre.phase", 32'(phase), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("wrap.instr_count", 32'(instr_count), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("post_wrap.instr_count", 32'(instr_count), 32'd1);

    // Asynchronous reset during a stall at phase 3.
    for (int i = 0; i < 3; i++) tick();
    wr        = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    chk_all("pre_reset_stall", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    wr        = 1'b0;
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_all("post_reset_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum consecutive memory wait cycles in one phase before a timeout.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clk  in  1  single clock, rising-edge active.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 run_req  in  1  start or resume continuous execution.
REQ-006 step_req  in  1  execute exactly one instruction.
REQ-007 halt  in  1  halt decode from the controller, valid in phase 4.
REQ-008 rd  in  1  memory read strobe from the controller.
REQ-009 wr  in  1  memory write strobe from the controller.
REQ-010 mem_ready  in  1  memory completes the current access this cycle.
REQ-011 phase  out  3  current instruction phase, 0..7, driven to the controller.
REQ-012 running  out  1  high in the RUN or STEP state.
REQ-013 halted  out  1  high in the HALTED state.
REQ-014 stall  out  1  high in any cycle where the phase is held for memory.
REQ-015 mem_timeout  out  1  sticky flag: a wait-state timeout occurred.
REQ-016 instr_count  out  CNT_W  number of retired instructions.

Function
REQ-017 States: IDLE, RUN, STEP, HALTED; the state register is updated only on clk.
REQ-018 IDLE: phase holds at 0; run_req moves to RUN; otherwise step_req moves to STEP; if both are high, RUN wins.
REQ-019 RUN/STEP phase advance: phase increments by 1 per cycle, 7 wraps to 0, unless stalled.
REQ-020 Stall: in RUN/STEP, when (rd|wr)=1 and mem_ready=0, phase holds, stall=1, and the wait counter increments; the wait counter clears whenever phase advances.
REQ-021 Timeout: if the wait counter reaches MAX_WAIT while still stalled, the next state is HALTED, phase becomes 0, and mem_timeout sets to 1.
REQ-022 mem_timeout clears only on reset or on a run_req accepted in HALTED.
REQ-023 Halt: when phase is 4 with halt=1 and no stall, the next state is HALTED and the next phase is 0.
REQ-024 A halted instruction does not increment instr_count.
REQ-025 Retirement: the transition from phase 7 to phase 0 increments instr_count by 1, wrapping from all-ones to 0.
REQ-026 STEP: after the phase 7 to phase 0 transition, the next state is IDLE.
REQ-027 In STEP, halt or timeout takes priority and goes to HALTED.
REQ-028 RUN: run_req and step_req are ignored.
REQ-029 STEP: run_req promotes to RUN without disturbing phase.
REQ-030 HALTED: phase holds at 0; run_req moves to RUN starting at phase 0; step_req moves to STEP; neither input changes instr_count.
REQ-031 Priority when events coincide: timeout > halt > retirement/step-complete > run/step requests.
REQ-032 run_req and step_req are level-sampled; a request held high in IDLE after STEP completes starts a new instruction on the next cycle.
REQ-033 Outputs are registered or decoded from the state only; there is no combinational path from any input to any output.

Reset
REQ-034 rst=1 immediately forces: state=IDLE, phase=0, running=0, halted=0, stall=0, mem_timeout=0, instr_count=0, wait counter=0.
REQ-035 Reset asserted mid-instruction, including during a stall, abandons the instruction with no retirement.
REQ-036 Release is synchronous to clk, and the first clk edge after release evaluates IDLE.

Structure
REQ-037 The shared package holds the state enumeration (IDLE, RUN, STEP, HALTED) and the phase constants PH_HALT_CHK=4 and PH_LAST=7, also used by the controller.
REQ-038 One sub-module, wait_timer, holds the wait counter, clear/increment, and the MAX_WAIT compare.
REQ-039 All other logic is in phase_sequencer.

Verification
REQ-040 Reset, then run_req pulse, mem_ready=1, halt=0, for 16 cycles -> phase 0..7,0..7; instr_count=2; running=1.
REQ-041 step_req pulse -> phases 0..7 once, then IDLE with phase=0, running=0, instr_count=1.
REQ-042 In RUN, phase 1 with rd=1 and mem_ready=0 for 3 cycles -> phase stays 1 and stall=1 for 3 cycles, then phase=2.
REQ-043 rd=1, mem_ready=0 held 20 cycles with MAX_WAIT=15 -> HALTED after the 15th wait, mem_timeout=1, phase=0; a later run_req clears mem_timeout.
REQ-044 halt=1 at phase 4 -> halted=1, phase=0, instr_count unchanged.
REQ-045 instr_count preset near all-ones via 65535 retirements -> wraps to 0.
REQ-046 rst asserted mid-stall in phase 3 -> all outputs return to reset values asynchronously, before the next clk edge.
